// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths and types
package cpu_pkg;

    localparam int W     = 32;
    localparam int NREGS = 16;

    typedef logic [3:0] reg_sel_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
    } flags_t;

endpackage

// File: rtl/rf_bypass.sv
// rtl/rf_bypass.sv - register file read mux with write-back bypass
module rf_bypass #(
    parameter int W    = 32,
    parameter int SELW = 4
) (
    input  logic [SELW-1:0] sel_i,
    input  logic            wb_valid_i,
    input  logic [SELW-1:0] wb_sel_i,
    input  logic [W-1:0]    wb_data_i,
    input  logic            wbq_valid_i,
    input  logic [SELW-1:0] wbq_sel_i,
    input  logic [W-1:0]    wbq_data_i,
    input  logic [W-1:0]    reg_data_i,
    output logic [W-1:0]    data_o
);

    // r0 wins over any bypass so writes to it are never visible
    always_comb begin
        data_o = reg_data_i;
        if (sel_i == '0) begin
            data_o = '0;
        end else if (wb_valid_i && (wb_sel_i == sel_i)) begin
            data_o = wb_data_i;
        end else if (wbq_valid_i && (wbq_sel_i == sel_i)) begin
            data_o = wbq_data_i;
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - ALU operand register file, write-back stage and flags
module alu_regfile #(
    parameter int NREGS = 16,
    parameter int W     = 32,
    parameter int SELW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SELW-1:0] rd_a_sel,
    input  logic [SELW-1:0] rd_b_sel,
    output logic [W-1:0]    arg_a,
    output logic [W-1:0]    arg_b,
    input  logic            wb_valid,
    input  logic [SELW-1:0] wb_sel,
    input  logic [W-1:0]    wb_data,
    input  logic            flags_we,
    input  logic            z_in,
    input  logic            c_in,
    input  logic            n_in,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_n,
    output logic            carry_out
);

    import cpu_pkg::*;

    logic [W-1:0]    regs_q [NREGS];
    logic            wbq_valid_q, wbq_valid_d;
    logic [SELW-1:0] wbq_sel_q, wbq_sel_d;
    logic [W-1:0]    wbq_data_q, wbq_data_d;
    flags_t          flags_q, flags_d;

    always_comb begin
        wbq_valid_d = wb_valid;
        wbq_sel_d   = wbq_sel_q;
        wbq_data_d  = wbq_data_q;
        flags_d     = flags_q;
        if (wb_valid) begin
            wbq_sel_d  = wb_sel;
            wbq_data_d = wb_data;
        end
        if (flags_we) begin
            flags_d = '{z: z_in, c: c_in, n: n_in};
        end
    end

    // Commit of the older write and capture of the newer one share an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wbq_valid_q <= 1'b0;
            wbq_sel_q   <= '0;
            wbq_data_q  <= '0;
            flags_q     <= '0;
        end else begin
            if (wbq_valid_q && (wbq_sel_q != '0)) begin
                regs_q[wbq_sel_q] <= wbq_data_q;
            end
            wbq_valid_q <= wbq_valid_d;
            wbq_sel_q   <= wbq_sel_d;
            wbq_data_q  <= wbq_data_d;
            flags_q     <= flags_d;
        end
    end

    rf_bypass #(.W(W), .SELW(SELW)) u_bypass_a (
        .sel_i       (rd_a_sel),
        .wb_valid_i  (wb_valid),
        .wb_sel_i    (wb_sel),
        .wb_data_i   (wb_data),
        .wbq_valid_i (wbq_valid_q),
        .wbq_sel_i   (wbq_sel_q),
        .wbq_data_i  (wbq_data_q),
        .reg_data_i  (regs_q[rd_a_sel]),
        .data_o      (arg_a)
    );

    rf_bypass #(.W(W), .SELW(SELW)) u_bypass_b (
        .sel_i       (rd_b_sel),
        .wb_valid_i  (wb_valid),
        .wb_sel_i    (wb_sel),
        .wb_data_i   (wb_data),
        .wbq_valid_i (wbq_valid_q),
        .wbq_sel_i   (wbq_sel_q),
        .wbq_data_i  (wbq_data_q),
        .reg_data_i  (regs_q[rd_b_sel]),
        .data_o      (arg_b)
    );

    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_n    = flags_q.n;
    assign carry_out = flags_q.c;

endmodule
